// File: rtl/fft_mdc_pkg.sv
// Shared constants and types for the 32-point radix-2 MDC FFT datapath.
// Holds the default component width, the per-stage commutator delays and the complex sample type.
package fft_mdc_pkg;

  localparam int WIDTH_DEF = 10;

  localparam int DELAY_S0 = 16;
  localparam int DELAY_S1 = 8;
  localparam int DELAY_S2 = 4;
  localparam int DELAY_S3 = 2;
  localparam int DELAY_S4 = 1;

  typedef struct packed {
    logic signed [WIDTH_DEF-1:0] re;
    logic signed [WIDTH_DEF-1:0] im;
  } cplx_t;

endpackage

// File: rtl/mdc_commutator_if.sv
// Two-lane complex sample bus between MDC butterfly stages.
// The master drives the a/b input pair; the slave returns the re-paired c/d lanes.
interface mdc_commutator_if #(parameter int WIDTH = 10);

  logic                    in_valid;
  logic signed [WIDTH-1:0] a_re;
  logic signed [WIDTH-1:0] a_im;
  logic signed [WIDTH-1:0] b_re;
  logic signed [WIDTH-1:0] b_im;
  logic                    out_valid;
  logic signed [WIDTH-1:0] c_re;
  logic signed [WIDTH-1:0] c_im;
  logic signed [WIDTH-1:0] d_re;
  logic signed [WIDTH-1:0] d_im;

  modport master (
    output in_valid, a_re, a_im, b_re, b_im,
    input  out_valid, c_re, c_im, d_re, d_im
  );

  modport slave (
    input  in_valid, a_re, a_im, b_re, b_im,
    output out_valid, c_re, c_im, d_re, d_im
  );

endinterface

// File: rtl/mdc_delay_line.sv
// Enable-gated shift register of complex samples, DEPTH entries deep.
// The output is the sample written DEPTH enabled edges ago; contents are deliberately not reset.
module mdc_delay_line #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    i_en,
  input  logic signed [WIDTH-1:0] i_re,
  input  logic signed [WIDTH-1:0] i_im,
  output logic signed [WIDTH-1:0] o_re,
  output logic signed [WIDTH-1:0] o_im
);

  logic [2*WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[0] <= {i_re, i_im};
      for (int i = 1; i < DEPTH; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
    end
  end

  assign {o_re, o_im} = r_mem[DEPTH-1];

endmodule

// File: rtl/mdc_commutator.sv
// Delay commutator between MDC butterfly stages: re-pairs lanes so the next stage sees samples DELAY apart.
// Optional MDC_COMM_BYPASS_EN adds a bypass port that passes a/b straight to c/d.
module mdc_commutator
  import fft_mdc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DELAY = DELAY_S1
) (
  input  logic clk,
  input  logic rst,
`ifdef MDC_COMM_BYPASS_EN
  input  logic bypass,
`endif
  mdc_commutator_if.slave bus
);

  localparam int CW = $clog2(DELAY) + 1;
  localparam int FW = CW + 1;
  localparam logic [FW-1:0] FILL_MAX = FW'(2 * DELAY);

  logic [CW-1:0]           r_cnt;
  logic [FW-1:0]           r_fill;
  logic                    r_outValid;
  logic signed [WIDTH-1:0] r_cRe, r_cIm, r_dRe, r_dIm;

  logic                    w_sel, w_filled, w_advance, w_shift, w_bypass, w_clear;
  logic signed [WIDTH-1:0] w_pRe, w_pIm, w_q0Re, w_q0Im, w_q1Re, w_q1Im, w_bRe, w_bIm;

`ifdef MDC_COMM_BYPASS_EN
  logic r_bypassPrev;

  always_ff @(posedge clk) begin
    if (rst) r_bypassPrev <= 1'b0;
    else     r_bypassPrev <= bypass;
  end

  assign w_bypass = bypass;
  assign w_clear  = (bypass != r_bypassPrev);
`else
  assign w_bypass = 1'b0;
  assign w_clear  = 1'b0;
`endif

  // The sample on a mode-change edge is dropped so the commutator refills from a clean index.
  assign w_advance = bus.in_valid && !w_bypass && !w_clear;
  assign w_shift   = w_advance && !rst;
  assign w_sel     = r_cnt[CW-1];
  assign w_filled  = (r_fill == FILL_MAX);

  mdc_delay_line #(.WIDTH(WIDTH), .DEPTH(DELAY)) u_lineA (
    .clk  (clk),
    .i_en (w_shift),
    .i_re (bus.a_re),
    .i_im (bus.a_im),
    .o_re (w_pRe),
    .o_im (w_pIm)
  );

  always_comb begin
    w_q0Re = w_pRe;
    w_q0Im = w_pIm;
    w_q1Re = bus.b_re;
    w_q1Im = bus.b_im;
    if (w_sel) begin
      w_q0Re = bus.b_re;
      w_q0Im = bus.b_im;
      w_q1Re = w_pRe;
      w_q1Im = w_pIm;
    end
  end

  mdc_delay_line #(.WIDTH(WIDTH), .DEPTH(DELAY)) u_lineB (
    .clk  (clk),
    .i_en (w_shift),
    .i_re (w_q0Re),
    .i_im (w_q0Im),
    .o_re (w_bRe),
    .o_im (w_bIm)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_fill     <= '0;
      r_outValid <= 1'b0;
      r_cRe      <= '0;
      r_cIm      <= '0;
      r_dRe      <= '0;
      r_dIm      <= '0;
    end else begin
      if (w_clear) begin
        r_cnt  <= '0;
        r_fill <= '0;
      end else if (w_advance) begin
        r_cnt <= r_cnt + CW'(1);
        if (!w_filled) r_fill <= r_fill + FW'(1);
      end
      if (w_bypass) begin
        r_outValid <= bus.in_valid;
        if (bus.in_valid) begin
          r_cRe <= bus.a_re;
          r_cIm <= bus.a_im;
          r_dRe <= bus.b_re;
          r_dIm <= bus.b_im;
        end
      end else begin
        r_outValid <= w_advance && w_filled;
        if (w_advance && w_filled) begin
          r_cRe <= w_bRe;
          r_cIm <= w_bIm;
          r_dRe <= w_q1Re;
          r_dIm <= w_q1Im;
        end
      end
    end
  end

  assign bus.out_valid = r_outValid;
  assign bus.c_re      = r_cRe;
  assign bus.c_im      = r_cIm;
  assign bus.d_re      = r_dRe;
  assign bus.d_im      = r_dIm;

endmodule

// File: tb/tb_mdc_commutator.sv
// Scoreboard bench for mdc_commutator: DELAY=4 and DELAY=1 instances share one stimulus stream.
// Expected c/d pairs are built from the accepted-sample history and compared one cycle later.
module tb_mdc_commutator;
  import fft_mdc_pkg::*;

  localparam int W = WIDTH_DEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef MDC_COMM_BYPASS_EN
  logic bypass = 1'b0;
`endif

  mdc_commutator_if #(.WIDTH(W)) bus4 ();
  mdc_commutator_if #(.WIDTH(W)) bus1 ();

  mdc_commutator #(.WIDTH(W), .DELAY(4)) u_dut4 (
    .clk    (clk),
    .rst    (rst),
`ifdef MDC_COMM_BYPASS_EN
    .bypass (bypass),
`endif
    .bus    (bus4.slave)
  );

  mdc_commutator #(.WIDTH(W), .DELAY(1)) u_dut1 (
    .clk    (clk),
    .rst    (rst),
`ifdef MDC_COMM_BYPASS_EN
    .bypass (bypass),
`endif
    .bus    (bus1.slave)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic [4*W-1:0] hist [$];
  logic [4*W-1:0] q4 [$];
  logic [4*W-1:0] q1 [$];
  logic [4*W-1:0] last4 = '0;
  logic [4*W-1:0] last1 = '0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // History entries are {a_re, a_im, b_re, b_im}; the result is {c_re, c_im, d_re, d_im}.
  function automatic logic [4*W-1:0] modelOut(input int d, input int n);
    logic [4*W-1:0] x, y;
    if (((n / d) % 2) == 0) begin
      x = hist[n-d];
      y = hist[n];
      return {x[2*W-1:0], y[2*W-1:0]};
    end else begin
      x = hist[n-2*d];
      y = hist[n-d];
      return {x[4*W-1:2*W], y[4*W-1:2*W]};
    end
  endfunction

  task automatic applyStimulus(input logic v, input logic signed [W-1:0] ar, input logic signed [W-1:0] ai,
                               input logic signed [W-1:0] br, input logic signed [W-1:0] bi);
    int  n;
    logic expV4, expV1;
    bus4.in_valid = v; bus4.a_re = ar; bus4.a_im = ai; bus4.b_re = br; bus4.b_im = bi;
    bus1.in_valid = v; bus1.a_re = ar; bus1.a_im = ai; bus1.b_re = br; bus1.b_im = bi;
    expV4 = 1'b0;
    expV1 = 1'b0;
    if (v) begin
      hist.push_back({ar, ai, br, bi});
      n = hist.size() - 1;
      if (n >= 8) begin q4.push_back(modelOut(4, n)); expV4 = 1'b1; end
      if (n >= 2) begin q1.push_back(modelOut(1, n)); expV1 = 1'b1; end
    end
    @(posedge clk);
    #1;
    checkOutput("valid4", {63'd0, bus4.out_valid}, {63'd0, expV4});
    if (expV4) last4 = q4.pop_front();
    checkOutput("cd4", {24'd0, bus4.c_re, bus4.c_im, bus4.d_re, bus4.d_im}, {24'd0, last4});
    checkOutput("valid1", {63'd0, bus1.out_valid}, {63'd0, expV1});
    if (expV1) last1 = q1.pop_front();
    checkOutput("cd1", {24'd0, bus1.c_re, bus1.c_im, bus1.d_re, bus1.d_im}, {24'd0, last1});
  endtask

  // Reset may coincide with in_valid; that sample must be dropped.
  task automatic doReset(input logic v);
    rst = 1'b1;
    bus4.in_valid = v;
    bus1.in_valid = v;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus4.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
    hist.delete();
    q4.delete();
    q1.delete();
    last4 = '0;
    last1 = '0;
    checkOutput("rstValid4", {63'd0, bus4.out_valid}, 64'd0);
    checkOutput("rstData4", {24'd0, bus4.c_re, bus4.c_im, bus4.d_re, bus4.d_im}, 64'd0);
    checkOutput("rstValid1", {63'd0, bus1.out_valid}, 64'd0);
    checkOutput("rstData1", {24'd0, bus1.c_re, bus1.c_im, bus1.d_re, bus1.d_im}, 64'd0);
  endtask

  task automatic patternStep(input int k);
    applyStimulus(1'b1, W'(k), W'(-k), W'(100 + k), W'(-(100 + k)));
  endtask

  initial begin
    bus4.in_valid = 1'b0; bus4.a_re = '0; bus4.a_im = '0; bus4.b_re = '0; bus4.b_im = '0;
    bus1.in_valid = 1'b0; bus1.a_re = '0; bus1.a_im = '0; bus1.b_re = '0; bus1.b_im = '0;
    repeat (2) @(posedge clk);
    #1;
    doReset(1'b0);

    for (int k = 0; k < 16; k++) begin
      patternStep(k);
      if (k == 2)  checkOutput("first1", {44'd0, bus1.c_re, bus1.d_re}, {44'd0, W'(101), W'(102)});
      if (k == 3)  checkOutput("odd1", {44'd0, bus1.c_re, bus1.d_re}, {44'd0, W'(1), W'(2)});
      if (k == 8)  checkOutput("fill4", {44'd0, bus4.c_re, bus4.d_re}, {44'd0, W'(104), W'(108)});
      if (k == 12) checkOutput("odd4", {44'd0, bus4.c_re, bus4.d_re}, {44'd0, W'(4), W'(8)});
    end

    doReset(1'b0);
    for (int k = 0; k <= 10; k++) patternStep(k);
    doReset(1'b1);
    for (int k = 0; k < 12; k++) begin
      patternStep(k);
      if (k == 8) checkOutput("refill4", {44'd0, bus4.c_re, bus4.d_re}, {44'd0, W'(104), W'(108)});
    end

    doReset(1'b0);
    for (int k = 0; k < 24; k++) begin
      patternStep(k);
      applyStimulus(1'b0, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    end

    for (int k = 0; k < 100; k++) begin
      applyStimulus($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mdc_commutator.md
# mdc_commutator

Inter-stage delay-commutator for the 32-point radix-2 MDC FFT datapath. It receives the two parallel complex output lanes of a butterfly stage and re-pairs them so that the next stage's butterfly sees samples spaced DELAY apart on its two inputs. It is built from two DELAY-deep delay lines and a 2x2 switch driven by the sample counter. One instance sits between every pair of butterfly stages, with DELAY halving stage by stage.

## Interface
- WIDTH, 10: bit width of each signed real/imag component; the same width on input and output.
- DELAY, 8: lane spacing in samples; power of two, 1..16.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  the a/b sample pair is accepted on this edge.
- a_re, a_im  input  WIDTH  upper lane (butterfly y0), signed.
- b_re, b_im  input  WIDTH  lower lane (butterfly y1), signed.
- out_valid  output  1  c/d hold a valid re-paired sample.
- c_re, c_im  output  WIDTH  upper output lane, signed, registered.
- d_re, d_im  output  WIDTH  lower output lane, signed, registered.
- bypass  input  1  present only with MDC_COMM_BYPASS_EN (see Configuration).

## Operation
- The sample index n counts accepted pairs from 0 after reset; n advances only on in_valid.
- All state (delay lines, counter) advances only on in_valid. When in_valid is 0, everything freezes, so gaps in the stream are transparent.
- Datapath:
  - Lane a passes through delay line A (DELAY samples), giving p = a[n-DELAY].
  - The switch select is sel = bit log2(DELAY) of n.
  - sel=0: q0 = p, q1 = b[n]. sel=1: q0 = b[n], q1 = p.
  - q0 passes through delay line B (DELAY samples). c = B output, d = q1.
- Resulting output at index n, for n >= 2*DELAY:
  - (n / DELAY) even: c = b[n-DELAY], d = b[n].
  - (n / DELAY) odd: c = a[n-2*DELAY], d = a[n-DELAY].
- Fill: a saturating fill counter tracks accepted samples. out_valid is asserted only for samples with n >= 2*DELAY.
- The counter that produces sel wraps modulo 2*DELAY. The fill counter saturates and never wraps.
- Arithmetic: none; data is routed only, with no growth and no truncation.

## Timing
- Latency: one cycle. The sample accepted at edge k produces c/d/out_valid visible after edge k.
- out_valid = registered (in_valid && filled). It is 0 in any cycle following an edge where in_valid was 0.
- c/d hold their last value while out_valid is 0.
- Reset values: out_valid=0; c_re, c_im, d_re, d_im = 0; n=0; fill=0.
- Delay-line contents need not be reset. Output is gated by fill, so stale data is never flagged valid.
- rst mid-stream: the next edge clears n and fill. The first valid output reappears 2*DELAY accepted samples later.
- rst and in_valid on the same edge: rst wins and the sample is dropped.

## Configuration
- MDC_COMM_BYPASS_EN defined: adds the bypass port.
  - bypass=1: c=a, d=b, registered with 1-cycle latency. out_valid = registered in_valid. The delay lines hold.
  - Any change of bypass clears n and fill on that edge, so re-entering commutate mode refills from zero.
- MDC_COMM_BYPASS_EN undefined: no bypass port; the block always commutates.

## Structure
- Shared package fft_mdc_pkg: default WIDTH, the stage DELAY constants (16, 8, 4, 2, 1), and the complex-sample struct {re, im}.
- Sub-module mdc_delay_line (parameters WIDTH and DEPTH; enable-gated shift register of complex samples). Instantiate it twice, as A and B.

## Test plan
- Fill latency: DELAY=4, continuous in_valid, a_re=n, a_im=-n, b_re=100+n, b_im=-(100+n) -> out_valid first rises after the 9th accepted sample (n=8), with c_re=104, d_re=108.
- Steady-state pattern, same stimulus -> n=8..11: c_re=104..107, d_re=108..111. n=12..15: c_re=4..7, d_re=8..11. Imag parts are the negated values throughout.
- Gaps: same as the fill-latency test, but in_valid toggled 1/0 -> identical c/d sequence on valid cycles, out_valid=0 after every idle cycle, outputs held.
- Reset mid-stream: assert rst at n=10 -> next cycle out_valid=0 and outputs 0. After release, out_valid reappears at the 9th accepted sample.
- DELAY=1 corner: b_re=100+n -> n=2: c_re=101, d_re=102. n=3: c_re=a[1], d_re=a[2].
- With MDC_COMM_BYPASS_EN: bypass=1 -> c=a, d=b one cycle later. Drop bypass at n=20 -> out_valid stays 0 for 8 accepted samples (DELAY=4).
